alu_seq_ctrl: RTL

- Sequencing stage directly upstream of the 8-bit combinational ALU unit.
- Accepts register-to-register commands over a valid/ready handshake, reads operands from a 4x8-bit register file, and drives the ALU's opA/opB/opcode/cin inputs.
- Captures the ALU result and carry-out, writes the result back to the register file, keeps a carry flag for multi-byte chains, and presents each result downstream with a valid/ready handshake.

---
 rtl/alu_seq_ctrl.sv | 104 ++++++++++
 1 files changed

// File: rtl/alu_seq_ctrl.sv
// Command sequencer in front of an 8-bit combinational ALU: reads a 4x8 register file,
// drives the ALU operands, writes the result back and hands it downstream over valid/ready.
module alu_seq_ctrl #(
  parameter int          NREG   = 4,
  parameter logic [3:0]  LDI_OP = 4'hF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [3:0]               cmd_op,
  input  logic [$clog2(NREG)-1:0]  cmd_dst,
  input  logic [$clog2(NREG)-1:0]  cmd_srca,
  input  logic [$clog2(NREG)-1:0]  cmd_srcb,
  input  logic                     cmd_usec,
  input  logic [7:0]               cmd_imm,
  output logic [7:0]               alu_opa,
  output logic [7:0]               alu_opb,
  output logic [3:0]               alu_opcode,
  output logic                     alu_cin,
  input  logic [7:0]               alu_result,
  input  logic                     alu_cout,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [7:0]               res_data,
  output logic [$clog2(NREG)-1:0]  res_dst,
  output logic                     carry
);

  localparam int IW = $clog2(NREG);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t          state, state_next;
  logic [7:0]      regs [NREG];
  logic [3:0]      op_q;
  logic [IW-1:0]   dst_q;
  logic [7:0]      imm_q;
  logic [7:0]      wdata;

  assign wdata = (op_q == LDI_OP) ? imm_q : alu_result;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves an output unassigned (no latches).
    state_next = state;
    cmd_ready  = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_next = EXEC;
      end
      EXEC:    state_next = DONE;
      DONE:    if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the register file is cleared on reset because software relies on it reading zero.
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      op_q       <= '0;
      dst_q      <= '0;
      imm_q      <= '0;
      alu_opa    <= '0;
      alu_opb    <= '0;
      alu_opcode <= '0;
      alu_cin    <= 1'b0;
      carry      <= 1'b0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_dst    <= '0;
    end else begin
      unique case (state)
        IDLE: if (cmd_valid) begin
          op_q       <= cmd_op;
          dst_q      <= cmd_dst;
          imm_q      <= cmd_imm;
          alu_opa    <= regs[cmd_srca];
          alu_opb    <= regs[cmd_srcb];
          alu_opcode <= cmd_op;
          alu_cin    <= cmd_usec & carry;
        end
        EXEC: begin
          // ALU output has settled combinationally from the operands registered in IDLE.
          regs[dst_q] <= wdata;
          if (op_q == 4'h0) carry <= alu_cout;
          res_data  <= wdata;
          res_dst   <= dst_q;
          res_valid <= 1'b1;
        end
        DONE: if (res_ready) res_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
